// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the instruction-fetch block.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Small synchronous FIFO holding {instruction, pc} pairs.
//             Flush overrides push and pop; head is visible combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam int                c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0]   c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]   c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0]   c_PTR_ONE = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pop on empty is ignored; a push into a full FIFO is only taken alongside a pop.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array; no reset needed since the head is qualified by empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == c_DEPTH);
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/modulo_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : modulo_fetch
//  Purpose  : Instruction fetch unit. Reads instruction memory at the PC over
//             a req/ack bus, buffers words with their PC, hands them to decode
//             over valid/ready, pulses pc_adv_o and flushes on redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module modulo_fetch #(
    parameter int DEPTH = 2,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    output logic            pc_adv_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    import fetch_pkg::*;

    localparam int              c_CW      = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [XLEN-1:0] c_STEP    = XLEN'(PC_STEP);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   w_addr_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_pc_adv;
    logic [2*XLEN-1:0] w_din;
    logic [2*XLEN-1:0] w_dout;
    logic [c_CW-1:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic [XLEN-1:0]   r_last_instr;
    logic [XLEN-1:0]   r_last_pc;

    // A redirect suppresses the pop so the flush cleanly wins.
    assign w_pop = instr_ready_i && !w_empty && !redirect_i;
    assign w_din = {imem_rdata_i, r_addr};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_i),
        .din   (w_din),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // State and request-address register; reset aborts any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Next-state, push and pc_adv decode; redirect outranks every other action.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_push      = 1'b0;
        w_pc_adv    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!redirect_i && !w_full) begin
                    w_state_nxt = WAIT;
                    w_addr_nxt  = pc_i;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    // An ack on the redirect edge closes the request; otherwise drain it.
                    w_state_nxt = imem_ack_i ? IDLE : DISCARD;
                end else if (imem_ack_i) begin
                    w_push   = 1'b1;
                    w_pc_adv = 1'b1;
                    // Back-to-back issue keeps one instruction per cycle with zero-wait memory.
                    if (((w_count + c_CNT_ONE) < c_DEPTH) || w_pop) begin
                        w_state_nxt = WAIT;
                        w_addr_nxt  = pc_i + c_STEP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (imem_ack_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Remember the most recent head so outputs hold steady while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else if (!w_empty) begin
            r_last_instr <= w_dout[2*XLEN-1:XLEN];
            r_last_pc    <= w_dout[XLEN-1:0];
        end
    end

    assign pc_adv_o      = w_pc_adv;
    assign imem_req_o    = (r_state != IDLE);
    assign imem_addr_o   = r_addr;
    assign instr_valid_o = !w_empty;
    assign instr_o       = w_empty ? r_last_instr : w_dout[2*XLEN-1:XLEN];
    assign instr_pc_o    = w_empty ? r_last_pc    : w_dout[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_modulo_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modulo_fetch
//  Purpose  : Directed self-checking bench for modulo_fetch with a simple
//             PC model standing in for modulo_PC.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        redirect_i;
    logic [31:0] target;
    logic        pc_adv_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int total = 0;
    int bad   = 0;

    modulo_fetch #(.DEPTH(2), .XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc),
        .redirect_i    (redirect_i),
        .pc_adv_o      (pc_adv_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    // Program-counter model: load target on redirect, step by 4 on pc_adv.
    always @(posedge clk) begin
        if (reset)           pc <= 32'd0;
        else if (redirect_i) pc <= target;
        else if (pc_adv_o)   pc <= pc + 32'd4;
    end

    task automatic do_reset();
        reset = 1'b1; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; target = 32'd0; imem_rdata_i = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; target = 32'd0; imem_rdata_i = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
            total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
            total++; if (pc_adv_o !== 1'b0) begin bad++; $display("FAIL rst_pcadv: got %b want 0", pc_adv_o); end
        end
        total++; if (imem_addr_o !== 32'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
        total++; if (instr_o !== 32'd0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr_o); end
        total++; if (instr_pc_o !== 32'd0) begin bad++; $display("FAIL rst_ipc: got %h want 0", instr_pc_o); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rst_first_req: got %b want 1", imem_req_o); end
        total++; if (imem_addr_o !== 32'd0) begin bad++; $display("FAIL rst_first_addr: got %h want 0", imem_addr_o); end
    endtask

    task automatic test_stream();
        do_reset();
        imem_ack_i = 1'b1; imem_rdata_i = 32'h00500093; instr_ready_i = 1'b1;
        @(negedge clk);
        total++; if (pc_adv_o !== 1'b1) begin bad++; $display("FAIL stream_pcadv0: got %b want 1", pc_adv_o); end
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL stream_valid0: got %b want 0", instr_valid_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (instr_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %b want 1", i, instr_valid_o); end
            total++; if (instr_o !== 32'h00500093) begin bad++; $display("FAIL stream_instr%0d: got %h want 00500093", i, instr_o); end
            total++; if (instr_pc_o !== 32'(4*i)) begin bad++; $display("FAIL stream_ipc%0d: got %h want %h", i, instr_pc_o, 32'(4*i)); end
            total++; if (pc_adv_o !== 1'b1) begin bad++; $display("FAIL stream_pcadv%0d: got %b want 1", i, pc_adv_o); end
        end
    endtask

    task automatic test_full();
        do_reset();
        imem_ack_i = 1'b1; imem_rdata_i = 32'h00000013; instr_ready_i = 1'b0;
        @(negedge clk);
        total++; if (pc_adv_o !== 1'b1) begin bad++; $display("FAIL full_pcadv1: got %b want 1", pc_adv_o); end
        @(negedge clk);
        total++; if (imem_addr_o !== 32'd4) begin bad++; $display("FAIL full_addr2: got %h want 4", imem_addr_o); end
        @(negedge clk);
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL full_req3: got %b want 0", imem_req_o); end
        total++; if (pc_adv_o !== 1'b0) begin bad++; $display("FAIL full_pcadv3: got %b want 0", pc_adv_o); end
        @(negedge clk);
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL full_req4: got %b want 0", imem_req_o); end
        total++; if (instr_pc_o !== 32'd0) begin bad++; $display("FAIL full_ipc4: got %h want 0", instr_pc_o); end
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL full_req5: got %b want 0", imem_req_o); end
        total++; if (instr_pc_o !== 32'd4) begin bad++; $display("FAIL full_ipc5: got %h want 4", instr_pc_o); end
        @(negedge clk);
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL full_req6: got %b want 1", imem_req_o); end
        total++; if (imem_addr_o !== 32'd8) begin bad++; $display("FAIL full_addr6: got %h want 8", imem_addr_o); end
        @(negedge clk);
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL full_req7: got %b want 0", imem_req_o); end
        total++; if (pc_adv_o !== 1'b0) begin bad++; $display("FAIL full_pcadv7: got %b want 0", pc_adv_o); end
        instr_ready_i = 1'b1;
        @(negedge clk);
        total++; if (instr_pc_o !== 32'd8) begin bad++; $display("FAIL full_ipc8: got %h want 8", instr_pc_o); end
        instr_ready_i = 1'b0; redirect_i = 1'b1; target = 32'h40;
        @(negedge clk);
        redirect_i = 1'b0;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", instr_valid_o); end
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL flush_req: got %b want 0", imem_req_o); end
        total++; if (instr_pc_o !== 32'd8) begin bad++; $display("FAIL flush_hold_ipc: got %h want 8", instr_pc_o); end
    endtask

    task automatic test_redirect_discard();
        do_reset();
        imem_ack_i = 1'b0; instr_ready_i = 1'b1; imem_rdata_i = 32'hDEAD0001;
        @(negedge clk);
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL disc_req1: got %b want 1", imem_req_o); end
        redirect_i = 1'b1; target = 32'd30;
        @(negedge clk);
        redirect_i = 1'b0;
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL disc_req_held: got %b want 1", imem_req_o); end
        total++; if (imem_addr_o !== 32'd0) begin bad++; $display("FAIL disc_addr_held: got %h want 0", imem_addr_o); end
        @(negedge clk);
        imem_ack_i = 1'b1;
        #1;
        total++; if (pc_adv_o !== 1'b0) begin bad++; $display("FAIL disc_pcadv: got %b want 0", pc_adv_o); end
        @(negedge clk);
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL disc_idle_req: got %b want 0", imem_req_o); end
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL disc_valid: got %b want 0", instr_valid_o); end
        imem_rdata_i = 32'h00A00113;
        @(negedge clk);
        total++; if (imem_addr_o !== 32'd30) begin bad++; $display("FAIL disc_newaddr: got %h want 1e", imem_addr_o); end
        total++; if (pc_adv_o !== 1'b1) begin bad++; $display("FAIL disc_newpcadv: got %b want 1", pc_adv_o); end
        @(negedge clk);
        total++; if (instr_pc_o !== 32'd30) begin bad++; $display("FAIL disc_ipc: got %h want 1e", instr_pc_o); end
        total++; if (instr_o !== 32'h00A00113) begin bad++; $display("FAIL disc_instr: got %h want 00a00113", instr_o); end
    endtask

    task automatic test_redirect_on_ack();
        do_reset();
        imem_ack_i = 1'b0; instr_ready_i = 1'b1; imem_rdata_i = 32'hDEAD0002;
        @(negedge clk);
        imem_ack_i = 1'b1; redirect_i = 1'b1; target = 32'h100;
        #1;
        total++; if (pc_adv_o !== 1'b0) begin bad++; $display("FAIL rack_pcadv: got %b want 0", pc_adv_o); end
        @(negedge clk);
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rack_idle: got %b want 0", imem_req_o); end
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rack_valid: got %b want 0", instr_valid_o); end
        imem_ack_i = 1'b0; redirect_i = 1'b0; imem_rdata_i = 32'h00100073;
        @(negedge clk);
        total++; if (imem_addr_o !== 32'h100) begin bad++; $display("FAIL rack_addr: got %h want 100", imem_addr_o); end
        imem_ack_i = 1'b1;
        @(negedge clk);
        imem_ack_i = 1'b0;
        total++; if (instr_pc_o !== 32'h100) begin bad++; $display("FAIL rack_ipc: got %h want 100", instr_pc_o); end
        total++; if (instr_o !== 32'h00100073) begin bad++; $display("FAIL rack_instr: got %h want 00100073", instr_o); end
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        @(negedge clk);
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL mid_req1: got %b want 1", imem_req_o); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL mid_req_drop: got %b want 0", imem_req_o); end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD0003;
        #1;
        total++; if (pc_adv_o !== 1'b0) begin bad++; $display("FAIL mid_pcadv: got %b want 0", pc_adv_o); end
        @(negedge clk);
        reset = 1'b0; imem_ack_i = 1'b0;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", instr_valid_o); end
        @(negedge clk);
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid2: got %b want 0", instr_valid_o); end
        total++; if (instr_o !== 32'd0) begin bad++; $display("FAIL mid_instr: got %h want 0", instr_o); end
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL mid_reissue: got %b want 1", imem_req_o); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect_i = 1'b1; target = 32'hFFFFFFFC;
        imem_ack_i = 1'b1; instr_ready_i = 1'b1; imem_rdata_i = 32'h0000006F;
        @(negedge clk);
        redirect_i = 1'b0;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL wrap_noissue: got %b want 0", imem_req_o); end
        @(negedge clk);
        total++; if (imem_addr_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr_o); end
        @(negedge clk);
        total++; if (imem_addr_o !== 32'd0) begin bad++; $display("FAIL wrap_addr0: got %h want 0", imem_addr_o); end
        total++; if (instr_pc_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_ipc: got %h want fffffffc", instr_pc_o); end
        @(negedge clk);
        total++; if (instr_pc_o !== 32'd0) begin bad++; $display("FAIL wrap_ipc0: got %h want 0", instr_pc_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_discard();
        test_redirect_on_ack();
        test_reset_mid_request();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
